alu_commit_stage: RTL and testbench

ALU_COMMIT_STAGE -- requirements
Module: alu_commit_stage

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_flag_reg.sv | 55 +++++
 rtl/alu_commit_stage.sv | 117 +++++++++++
 tb/tb_alu_commit_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and opcode classification
// used by the ALU commit stage and its flag register.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_RSV6 = 3'b110;
    localparam logic [2:0] OP_RSV7 = 3'b111;

    // Bit positions inside the {Z,V,N} condition-code vector.
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Arithmetic ops update all flags, logic ops only Z, reserved ops none.
    typedef enum logic [1:0] {
        CLS_ARITH = 2'd0,
        CLS_LOGIC = 2'd1,
        CLS_RSVD  = 2'd2
    } op_class_e;

    function automatic op_class_e op_class(input logic [2:0] op);
        op_class_e cls;
        case (op)
            OP_ADD, OP_SUB, OP_MUL: cls = CLS_ARITH;
            OP_AND, OP_OR, OP_XOR:  cls = CLS_LOGIC;
            default:                cls = CLS_RSVD;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Committed condition codes {Z,V,N} and the sticky illegal-opcode flag.
// State only changes on a commit; the op class decides which bits move.
module alu_flag_reg
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       commit_en_i,
    input  op_class_e  op_class_i,
    input  logic       zero_i,
    input  logic       ovfl_i,
    input  logic       neg_i,
    output logic [2:0] flags_o,
    output logic       illegal_op_o
);

    logic [2:0] flags_q, flags_d;
    logic       illegal_q, illegal_d;

    // Next-state: select which flag bits the committing op may change.
    always_comb begin
        flags_d   = flags_q;
        illegal_d = illegal_q;
        if (commit_en_i) begin
            case (op_class_i)
                CLS_ARITH: begin
                    flags_d[FLAG_Z] = zero_i;
                    flags_d[FLAG_V] = ovfl_i;
                    flags_d[FLAG_N] = neg_i;
                end
                CLS_LOGIC: begin
                    flags_d[FLAG_Z] = zero_i;
                end
                default: begin
                    illegal_d = 1'b1;
                end
            endcase
        end
    end

    // Flag state register; cleared only by reset, illegal_op is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= 3'b000;
            illegal_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    assign flags_o      = flags_q;
    assign illegal_op_o = illegal_q;

endmodule

// File: rtl/alu_commit_stage.sv
// ALU result commit stage: a small circular queue of ALU output bundles
// feeding writeback, with condition codes updated as each bundle commits.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The sender holds its bundle stable with valid high until it transfers;
// ready never depends combinationally on the partner's valid. in_ready is
// derived from registered occupancy only, so there is no out_ready ->
// in_ready path.
module alu_commit_stage
    import alu_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [W-1:0] in_result,
    input  logic         in_ovfl,
    input  logic         in_zero,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [2:0]   out_op,
    output logic [2:0]   flags,
    output logic         illegal_op
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Bundle storage; contents are meaningless while the slot is empty.
    logic [W-1:0] res_mem  [DEPTH];
    logic [2:0]   op_mem   [DEPTH];
    logic         ovfl_mem [DEPTH];
    logic         zero_mem [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;

    // in_ready is held low while reset is asserted, then follows occupancy.
    assign in_ready  = rst_n && (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign out_result = res_mem[head_q];
    assign out_op     = op_mem[head_q];

    // Flush drops an incoming bundle but still lets the head commit.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready;

    // Pointer and occupancy next-state; pointers wrap since DEPTH is 2^PW.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Queue control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write the accepted bundle into the tail slot; storage is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[tail_q]  <= in_result;
            op_mem[tail_q]   <= in_op;
            ovfl_mem[tail_q] <= in_ovfl;
            zero_mem[tail_q] <= in_zero;
        end
    end

    alu_flag_reg u_flag_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .commit_en_i  (pop),
        .op_class_i   (op_class(op_mem[head_q])),
        .zero_i       (zero_mem[head_q]),
        .ovfl_i       (ovfl_mem[head_q]),
        .neg_i        (res_mem[head_q][W-1]),
        .flags_o      (flags),
        .illegal_op_o (illegal_op)
    );

endmodule

// File: tb/tb_alu_commit_stage.sv
// Bench for alu_commit_stage: directed scenarios plus a random stream,
// with a queue scoreboard and an independent condition-code model.
module tb_alu_commit_stage;

    localparam int W  = 4;
    localparam int EW = 3 + W + 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_result;
    logic         in_ovfl;
    logic         in_zero;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [2:0]   out_op;
    logic [2:0]   flags;
    logic         illegal_op;

    // Scoreboard entry: {op, result, ovfl, zero}.
    logic [EW-1:0] exp_q[$];
    logic [2:0]    exp_flags;
    logic          exp_illegal;

    int n_checks;
    int n_pass;

    alu_commit_stage #(.W(W), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_result  (in_result),
        .in_ovfl    (in_ovfl),
        .in_zero    (in_zero),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .flags      (flags),
        .illegal_op (illegal_op)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present a bundle and raise in_valid.
    task automatic drive(input logic [2:0] op, input logic [W-1:0] res,
                         input logic ov, input logic z);
        in_op     = op;
        in_result = res;
        in_ovfl   = ov;
        in_zero   = z;
        in_valid  = 1'b1;
    endtask

    // One clock cycle. On the falling edge the scoreboard checks the flags
    // against the model, predicts the transfers of the coming rising edge
    // and compares any committed head. Inputs change at posedge + 1.
    task automatic tick();
        logic [EW-1:0] e;
        @(negedge clk);
        if (rst_n) begin
            n_checks++;
            if (flags !== exp_flags)
                $display("FAIL sb_flags: got %b expected %b", flags, exp_flags);
            else
                n_pass++;
            n_checks++;
            if (illegal_op !== exp_illegal)
                $display("FAIL sb_illegal: got %b expected %b", illegal_op, exp_illegal);
            else
                n_pass++;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_commit: got op %b result %b expected no bundle",
                             out_op, out_result);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_op, out_result} !== e[EW-1:2])
                        $display("FAIL sb_commit: got op %b result %b expected op %b result %b",
                                 out_op, out_result, e[EW-1:W+2], e[W+1:2]);
                    else
                        n_pass++;
                    case (e[EW-1:W+2])
                        3'b000, 3'b001, 3'b101: exp_flags = {e[0], e[1], e[W+1]};
                        3'b010, 3'b011, 3'b100: exp_flags[2] = e[0];
                        default:                exp_illegal = 1'b1;
                    endcase
                end
            end
            if (flush)
                exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back({in_op, in_result, in_ovfl, in_zero});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_op = '0; in_result = '0; in_ovfl = 1'b0; in_zero = 1'b0;
        exp_flags = 3'b000; exp_illegal = 1'b0;
        #2;
        n_checks++;
        if ({out_valid, in_ready, flags, illegal_op} !== 6'b0)
            $display("FAIL reset_outputs: got v=%b r=%b f=%b i=%b expected all 0",
                     out_valid, in_ready, flags, illegal_op);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0",
                     in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_add_commit();
        out_ready = 1'b1;
        drive(3'b000, 4'b1000, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || flags !== 3'b000)
            $display("FAIL add_visible: got out_valid=%b flags=%b expected 1 000",
                     out_valid, flags);
        else n_pass++;
        tick();
        n_checks++;
        if (flags !== 3'b011 || out_valid !== 1'b0)
            $display("FAIL add_flags: got flags=%b out_valid=%b expected 011 0",
                     flags, out_valid);
        else n_pass++;
        // Empty queue with out_ready high must leave everything alone.
        tick();
        tick();
        n_checks++;
        if (flags !== 3'b011 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL empty_pop: got flags=%b out_valid=%b in_ready=%b expected 011 0 1",
                     flags, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_sub_xor();
        out_ready = 1'b1;
        drive(3'b001, 4'b0000, 1'b0, 1'b1);
        tick();
        drive(3'b100, 4'b0110, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (flags !== 3'b100 || out_valid !== 1'b1 || out_op !== 3'b100)
            $display("FAIL sub_flags: got flags=%b v=%b op=%b expected 100 1 100",
                     flags, out_valid, out_op);
        else n_pass++;
        tick();
        n_checks++;
        if (flags !== 3'b000 || out_valid !== 1'b0)
            $display("FAIL xor_flags: got flags=%b v=%b expected 000 0", flags, out_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic acc;
        out_ready = 1'b0;
        drive(3'b010, 4'b0011, 1'b0, 1'b0);
        tick();
        drive(3'b011, 4'b1100, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (in_ready !== 1'b0)
            $display("FAIL full_ready: got in_ready=%b expected 0", in_ready);
        else n_pass++;
        drive(3'b101, 4'b1110, 1'b1, 1'b0);
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_op !== 3'b010 || out_result !== 4'b0011)
            $display("FAIL full_hold: got r=%b op=%b res=%b expected 0 010 0011",
                     in_ready, out_op, out_result);
        else n_pass++;
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (!acc) $display("FAIL stall_accept: got no accept expected accept within 8");
        else n_pass++;
        for (int i = 0; i < 8 && out_valid; i++) tick();
        n_checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0 || flags !== 3'b011)
            $display("FAIL drain: got v=%b left=%0d flags=%b expected 0 0 011",
                     out_valid, exp_q.size(), flags);
        else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(3'b001, 4'b0101, 1'b0, 1'b0);
        tick();
        drive(3'b000, 4'b0001, 1'b0, 1'b0);
        tick();
        drive(3'b101, 4'b1111, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || flags !== 3'b011)
            $display("FAIL flush_full: got v=%b r=%b flags=%b expected 0 1 011",
                     out_valid, in_ready, flags);
        else n_pass++;
        // Flush with one bundle queued and a push offered: the push is dropped.
        drive(3'b010, 4'b0100, 1'b0, 1'b0);
        tick();
        drive(3'b000, 4'b1111, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || flags !== 3'b011)
            $display("FAIL flush_drop: got v=%b flags=%b expected 0 011", out_valid, flags);
        else n_pass++;
        // Flush while the head commits: the commit still updates flags.
        drive(3'b000, 4'b0111, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || flags !== 3'b000)
            $display("FAIL flush_commit: got v=%b flags=%b expected 0 000", out_valid, flags);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic acc;
        acc = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (!in_valid || acc) begin
                if ($urandom_range(0, 3) != 0)
                    drive(3'($urandom_range(0, 5)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else
                    in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && out_valid; i++) tick();
        n_checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0)
            $display("FAIL stream_drain: got v=%b left=%0d expected 0 0",
                     out_valid, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_illegal_and_async_reset();
        out_ready = 1'b1;
        drive(3'b110, 4'b1010, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (illegal_op !== 1'b1 || flags !== exp_flags || exp_illegal !== 1'b1)
            $display("FAIL illegal_commit: got i=%b flags=%b expected 1 %b",
                     illegal_op, flags, exp_flags);
        else n_pass++;
        out_ready = 1'b0;
        drive(3'b000, 4'b1001, 1'b1, 1'b0);
        tick();
        drive(3'b011, 4'b0010, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, flags, illegal_op} !== 6'b0)
            $display("FAIL async_reset: got v=%b r=%b f=%b i=%b expected all 0",
                     out_valid, in_ready, flags, illegal_op);
        else n_pass++;
        exp_q.delete();
        exp_flags = 3'b000;
        exp_illegal = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || illegal_op !== 1'b0)
            $display("FAIL post_reset: got r=%b v=%b i=%b expected 1 0 0",
                     in_ready, out_valid, illegal_op);
        else n_pass++;
        drive(3'b000, 4'b1001, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (flags !== 3'b001)
            $display("FAIL post_reset_add: got flags=%b expected 001", flags);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_add_commit();
        test_sub_xor();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_illegal_and_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
